// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA add/subtract sequencer.
package cla_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a 2-slice index still has one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cla_adder16.sv
// Combinational 16-bit carry-lookahead adder: 4-bit group generate/propagate
// with a second-level lookahead across the four groups.
module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co,
    output logic        c15
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;

        assign gg[k] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k] = p[B+3] & p[B+2] & p[B+1] & p[B];

        // Carries inside a group depend only on the group's own carry-in.
        assign c[B]   = cg[k];
        assign c[B+1] = g[B] | (p[B] & cg[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & cg[k]);
    end

    assign cg[0] = ci;
    assign cg[1] = gg[0] | (gp[0] & ci);
    assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & ci);
    assign cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

    assign s   = p ^ c;
    assign co  = cg[4];
    assign c15 = c[15];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 16-bit CLA processes
// one slice per cycle, LSW first, with the carry chained through a register.
module cla_mp_add_seq
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic                     cin,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] s_slice;
    logic               add_co;
    logic               add_c15;

    assign a_slice = a_reg[int'(idx)*SLICE_W +: SLICE_W];
    assign b_slice = b_reg[int'(idx)*SLICE_W +: SLICE_W];

    cla_adder16 u_adder (
        .a   (a_slice),
        .b   (b_slice),
        .ci  (carry),
        .s   (s_slice),
        .co  (add_co),
        .c15 (add_c15)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1 - borrow_in.
                        a_reg <= a;
                        b_reg <= op_sub ? ~b : b;
                        carry <= cin ^ op_sub;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[int'(idx)*SLICE_W +: SLICE_W] <= s_slice;
                    carry <= add_co;
                    if (idx == LAST_IDX) begin
                        cout  <= add_co;
                        ovf   <= add_co ^ add_c15;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Self-checking bench for cla_mp_add_seq with WORDS=4: vector table, random
// model-checked operations, back-to-back, ignored start and mid-run reset.
module tb_cla_mp_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         op_sub = 1'b0;
    logic         cin    = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    cla_mp_add_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic         op;
        logic         ci;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t sb[$];
    exp_t last_e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    logic both_seen = 1'b0;

    always @(negedge clk) if (busy && done) both_seen = 1'b1;

    function automatic exp_t model(input logic op, input logic ci,
                                   input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb     = op ? ~bv : bv;
        t      = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, ci ^ op};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (av[W-1] == bb[W-1]) && (t[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic op, input logic ci, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input exp_t e);
        op_sub = op;
        cin    = ci;
        a      = av;
        b      = bv;
        start  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        chk("busy_after_start", W'(busy), W'(1));
    endtask

    task automatic wait_done(input int poke_at);
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 1) chk("partial_upper_zero", {16'h0, sum[W-1:16]}, '0);
            if (n == poke_at) begin
                start  = 1'b1;
                op_sub = ~op_sub;
                a      = {$urandom, $urandom};
                b      = {$urandom, $urandom};
            end
        end
        start = 1'b0;
        chk("done_latency", W'(n), W'(WORDS));
        chk("done_seen", W'(done), W'(1));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", W'(0), W'(1));
        end else begin
            e = sb.pop_front();
            last_e = e;
            chk("sum", sum, e.sum);
            chk("cout", W'(cout), W'(e.cout));
            chk("ovf", W'(ovf), W'(e.ovf));
        end
    endtask

    task automatic idle_after;
        @(negedge clk);
        chk("done_one_cycle", W'(done), W'(0));
        chk("sum_held", sum, last_e.sum);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;
        logic         rci;

        vecs[0] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 64'h10, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 64'h0, 64'h0, 64'h1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
                    64'h0001_0000_0001_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h0, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_sum", sum, '0);
            chk("reset_flags", W'({busy, done, cout, ovf}), '0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_sum", sum, '0);
            chk("idle_flags", W'({busy, done, cout, ovf}), '0);
        end

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].ci, vecs[i].av, vecs[i].bv,
                  '{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
            wait_done(0);
            idle_after();
        end

        for (int i = 0; i < 6; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rop = 1'($urandom_range(0, 1));
            rci = 1'($urandom_range(0, 1));
            issue(rop, rci, ra, rb, model(rop, rci, ra, rb));
            wait_done(0);
        end
        idle_after();

        // Back-to-back: the next start is presented in the DONE cycle.
        issue(vecs[1].op, vecs[1].ci, vecs[1].av, vecs[1].bv,
              '{vecs[1].sum, vecs[1].cout, vecs[1].ovf});
        wait_done(0);
        issue(vecs[6].op, vecs[6].ci, vecs[6].av, vecs[6].bv,
              '{vecs[6].sum, vecs[6].cout, vecs[6].ovf});
        wait_done(0);
        idle_after();

        // Start pulse with fresh operands in the middle of RUN is ignored.
        issue(vecs[2].op, vecs[2].ci, vecs[2].av, vecs[2].bv,
              '{vecs[2].sum, vecs[2].cout, vecs[2].ovf});
        wait_done(2);
        idle_after();

        // Reset while slice index 2 is being computed.
        issue(vecs[5].op, vecs[5].ci, vecs[5].av, vecs[5].bv,
              '{vecs[5].sum, vecs[5].cout, vecs[5].ovf});
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", sum, '0);
        chk("abort_flags", W'({busy, done, cout, ovf}), '0);
        e = sb.pop_back();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", W'({busy, done}), '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", W'({busy, done}), '0);
        issue(vecs[0].op, vecs[0].ci, vecs[0].av, vecs[0].bv,
              '{vecs[0].sum, vecs[0].cout, vecs[0].ovf});
        wait_done(0);
        idle_after();

        chk("busy_done_exclusive", W'(both_seen), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
